// File: rtl/rvvi_frame_packer.sv
// rvvi_frame_packer: packs variable-length RVVI trace records into Ethernet
// frames on an AXI4 write-data stream. A frame is a header (MACs, types,
// frame number), one or more records, and a trailer word with the record
// count. Frames close on size limit, idle timeout or Flush, and are separated
// by a programmable gap.
module rvvi_frame_packer #(
    parameter  int DATA_W          = 32,
    parameter  int REC_W           = 1024,
    parameter  int MAX_FRAME_WORDS = 375,
    parameter  int INIT_TIMEOUT    = 4,
    localparam int HDR_WORDS       = 192 / DATA_W,
    localparam int REC_WORDS       = REC_W / DATA_W,
    localparam int RW_W            = $clog2(REC_WORDS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REC_W-1:0]    RecData,
    input  logic [RW_W-1:0]     RecWords,
    input  logic                RecValid,
    output logic                RecReady,
    input  logic                Flush,
    input  logic [47:0]         SrcMac,
    input  logic [47:0]         DstMac,
    input  logic [15:0]         EthType,
    input  logic [15:0]         AckType,
    input  logic [31:0]         IdleTimeout,
    input  logic [31:0]         InterPktGap,
    output logic [DATA_W-1:0]   RvviAxiWdata,
    output logic [DATA_W/8-1:0] RvviAxiWstrb,
    output logic                RvviAxiWlast,
    output logic                RvviAxiWvalid,
    input  logic                RvviAxiWready,
    output logic [63:0]         FrameCount
);

    // Word index must cover both the header (up to 6 words) and a full record.
    localparam int IDX_W = (RW_W > 3) ? RW_W : 3;

    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_HDR, ST_BODY, ST_OPEN, ST_TRAIL, ST_GAP
    } state_t;

    state_t              state_q;
    logic [31:0]         timer_q;
    logic [63:0]         frame_cnt_q;
    logic [15:0]         used_q;
    logic [15:0]         rec_cnt_q;
    logic [REC_W-1:0]    rec_reg_q;
    logic [RW_W-1:0]     rec_len_q;
    logic [IDX_W-1:0]    idx_q;
    logic                wvalid_q;
    logic                wlast_q;
    logic [DATA_W-1:0]   wdata_q;

    logic [RW_W-1:0]     eff_words;
    logic [31:0]         fit_sum;
    logic                fit;
    logic [191:0]        hdr_vec;
    logic [31:0]         nxt_idx;
    logic [DATA_W-1:0]   hdr_word_d;
    logic [DATA_W-1:0]   rec_word_d;
    logic [DATA_W-1:0]   trail_word_d;
    logic [31:0]         timer_inc;
    logic                handshake;

    // Fit test, next stream words, saturating timer and record-side ready.
    // NOTE: every signal gets a value on every path here, so no latch can be inferred.
    always_comb begin
        eff_words    = (RecWords == '0) ? RW_W'(1) : RecWords;
        fit_sum      = 32'(HDR_WORDS) + 32'(used_q) + 32'(eff_words) + 32'd1;
        fit          = (fit_sum <= 32'(MAX_FRAME_WORDS));
        hdr_vec      = {frame_cnt_q, AckType, EthType, DstMac, SrcMac};
        nxt_idx      = 32'(idx_q) + 32'd1;
        hdr_word_d   = (nxt_idx < 32'(HDR_WORDS)) ? hdr_vec[nxt_idx*DATA_W +: DATA_W] : '0;
        rec_word_d   = (nxt_idx < 32'(REC_WORDS)) ? rec_reg_q[nxt_idx*DATA_W +: DATA_W] : '0;
        trail_word_d = DATA_W'({rec_cnt_q, 16'h5256});
        timer_inc    = (timer_q == '1) ? timer_q : timer_q + 32'd1;
        handshake    = wvalid_q & RvviAxiWready;
        // Ready never looks at Wready: in OPEN no word is in flight.
        RecReady     = (state_q == ST_IDLE) |
                       ((state_q == ST_OPEN) & ~Flush & fit);
    end

    // Frame sequencer with registered stream outputs.
    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            timer_q     <= '0;
            frame_cnt_q <= '0;
            used_q      <= '0;
            rec_cnt_q   <= '0;
            rec_len_q   <= RW_W'(1);
            idx_q       <= '0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            wdata_q     <= '0;
            // NOTE: rec_reg_q is a pure data holder, always loaded before use, so it is not reset.
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (timer_q == 32'(INIT_TIMEOUT)) state_q <= ST_IDLE;
                    else                              timer_q <= timer_inc;
                end
                ST_IDLE: begin
                    if (RecValid) begin
                        rec_reg_q <= RecData;
                        rec_len_q <= eff_words;
                        rec_cnt_q <= 16'd1;
                        idx_q     <= '0;
                        wvalid_q  <= 1'b1;
                        wdata_q   <= hdr_vec[DATA_W-1:0];
                        state_q   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (handshake) begin
                        if (idx_q == IDX_W'(HDR_WORDS - 1)) begin
                            idx_q   <= '0;
                            wdata_q <= rec_reg_q[DATA_W-1:0];
                            state_q <= ST_BODY;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            wdata_q <= hdr_word_d;
                        end
                    end
                end
                ST_BODY: begin
                    if (handshake) begin
                        used_q <= used_q + 16'd1;
                        if (IDX_W'(rec_len_q) == idx_q + IDX_W'(1)) begin
                            wvalid_q <= 1'b0;
                            timer_q  <= '0;
                            state_q  <= ST_OPEN;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            wdata_q <= rec_word_d;
                        end
                    end
                end
                ST_OPEN: begin
                    if (!Flush && RecValid && fit) begin
                        rec_reg_q <= RecData;
                        rec_len_q <= eff_words;
                        rec_cnt_q <= rec_cnt_q + 16'd1;
                        idx_q     <= '0;
                        wvalid_q  <= 1'b1;
                        wdata_q   <= RecData[DATA_W-1:0];
                        state_q   <= ST_BODY;
                    end else if (Flush || RecValid || (timer_q == IdleTimeout)) begin
                        // Flush, a record that does not fit, or idle timeout all close the frame.
                        wvalid_q <= 1'b1;
                        wlast_q  <= 1'b1;
                        wdata_q  <= trail_word_d;
                        state_q  <= ST_TRAIL;
                    end else begin
                        timer_q <= timer_inc;
                    end
                end
                ST_TRAIL: begin
                    if (handshake) begin
                        frame_cnt_q <= frame_cnt_q + 64'd1;
                        used_q      <= '0;
                        rec_cnt_q   <= '0;
                        timer_q     <= '0;
                        wvalid_q    <= 1'b0;
                        wlast_q     <= 1'b0;
                        state_q     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (timer_q >= InterPktGap) state_q <= ST_IDLE;
                    else                        timer_q <= timer_inc;
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // A record too large for even an empty frame can never be sent.
    assert property (@(posedge clk) disable iff (reset)
        (RecValid && RecReady) |->
        (32'(HDR_WORDS) + 32'(eff_words) + 32'd1 <= 32'(MAX_FRAME_WORDS)));

    assign RvviAxiWdata  = wdata_q;
    assign RvviAxiWstrb  = '1;
    assign RvviAxiWlast  = wlast_q;
    assign RvviAxiWvalid = wvalid_q;
    assign FrameCount    = frame_cnt_q;

endmodule

// File: tb/tb_rvvi_frame_packer.sv
// Self-checking bench for rvvi_frame_packer: table of multi-record scenarios
// compared against a framing model, plus hand-written reset sequences.
module tb_rvvi_frame_packer;

    localparam int DATA_W  = 32;
    localparam int REC_W   = 3200;
    localparam int MAXW    = 375;
    localparam int INIT_TO = 4;
    localparam int HDRW    = 6;
    localparam int RW_W    = $clog2(REC_W / DATA_W + 1);

    localparam logic [47:0] SRC = 48'h0A0B_0C0D_0E0F;
    localparam logic [47:0] DST = 48'h1122_3344_5566;
    localparam logic [15:0] ETH = 16'h88B5;
    localparam logic [15:0] ACK = 16'hA5C3;

    logic               clk;
    logic               reset;
    logic [REC_W-1:0]   RecData;
    logic [RW_W-1:0]    RecWords;
    logic               RecValid;
    logic               RecReady;
    logic               Flush;
    logic [31:0]        IdleTimeout;
    logic [31:0]        InterPktGap;
    logic [DATA_W-1:0]  Wdata;
    logic [DATA_W/8-1:0] Wstrb;
    logic               Wlast;
    logic               Wvalid;
    logic               Wready;
    logic [63:0]        FrameCount;

    rvvi_frame_packer #(
        .DATA_W(DATA_W), .REC_W(REC_W), .MAX_FRAME_WORDS(MAXW), .INIT_TIMEOUT(INIT_TO)
    ) dut (
        .clk(clk), .reset(reset),
        .RecData(RecData), .RecWords(RecWords), .RecValid(RecValid), .RecReady(RecReady),
        .Flush(Flush), .SrcMac(SRC), .DstMac(DST), .EthType(ETH), .AckType(ACK),
        .IdleTimeout(IdleTimeout), .InterPktGap(InterPktGap),
        .RvviAxiWdata(Wdata), .RvviAxiWstrb(Wstrb), .RvviAxiWlast(Wlast),
        .RvviAxiWvalid(Wvalid), .RvviAxiWready(Wready), .FrameCount(FrameCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] hdr_w(input logic [63:0] fc, input int i);
        logic [191:0] h;
        h = {fc, ACK, ETH, DST, SRC};
        return h[i*32 +: 32];
    endfunction

    function automatic logic [31:0] rec_w(input int tag, input int k);
        return {16'(tag), 16'(k)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Ready driver: constant 1, or random per cycle in stall scenarios.
    initial begin
        Wready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            Wready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Stream monitor and stall-stability checker, sampled mid-cycle.
    logic [32:0] got_q[$];
    int          got_cyc[$];
    logic        prev_stall = 1'b0;
    logic [32:0] prev_word;
    always @(negedge clk) begin
        if (prev_stall) begin
            check("stall_wvalid_held", {63'd0, Wvalid}, 64'd1);
            check("stall_word_stable", {31'd0, Wlast, Wdata}, {31'd0, prev_word});
        end
        if (!reset && Wvalid && Wready) begin
            got_q.push_back({Wlast, Wdata});
            got_cyc.push_back(cyc);
        end
        prev_stall = !reset && Wvalid && !Wready;
        prev_word  = {Wlast, Wdata};
    end

    typedef struct {
        int nrec; int len; int idle; int gap; bit rnd; bit flush;
        int exp_frames; int exp_cnt1;
    } scn_t;
    scn_t tbl[9];

    // After reset release: RecReady low for cycles 0..4, high by cycle 6.
    task automatic init_check(input string pfx);
        for (int n = 0; n <= 6; n++) begin
            @(negedge clk);
            if (n <= 4) check($sformatf("%s_recready_c%0d", pfx, n), {63'd0, RecReady}, 64'd0);
            if (n == 6) check($sformatf("%s_recready_c6", pfx), {63'd0, RecReady}, 64'd1);
        end
        tick();
    endtask

    task automatic run_scn(input int id, input scn_t v, input logic [63:0] fc0,
                           output logic [63:0] fc_out);
        logic [32:0] exp_q[$];
        int          tr_idx[$];
        int          used, cnt, L, ok, n_bad, first_bad, nlast, t, d, expd;
        bit          open;
        logic [63:0] fc;
        logic [31:0] first_tr;
        // Framing model.
        L = (v.len == 0) ? 1 : v.len;
        fc = fc0; open = 0; used = 0; cnt = 0;
        for (int r = 0; r < v.nrec; r++) begin
            if (open && (v.flush || (HDRW + used + L + 1 > MAXW))) begin
                exp_q.push_back({1'b1, 16'(cnt), 16'h5256});
                tr_idx.push_back(exp_q.size() - 1);
                fc++; open = 0;
            end
            if (!open) begin
                for (int i = 0; i < HDRW; i++) exp_q.push_back({1'b0, hdr_w(fc, i)});
                open = 1; used = 0; cnt = 0;
            end
            for (int k = 0; k < L; k++) exp_q.push_back({1'b0, rec_w(id*16 + r, k)});
            used += L; cnt++;
        end
        exp_q.push_back({1'b1, 16'(cnt), 16'h5256});
        tr_idx.push_back(exp_q.size() - 1);

        // Stimulus: records offered back to back.
        got_q.delete(); got_cyc.delete();
        Flush = v.flush; IdleTimeout = v.idle; InterPktGap = v.gap; rand_rdy = v.rnd;
        for (int r = 0; r < v.nrec; r++) begin
            RecData = '0;
            for (int k = 0; k < L; k++) RecData[k*32 +: 32] = rec_w(id*16 + r, k);
            RecWords = RW_W'(v.len);
            RecValid = 1'b1;
            ok = 0;
            for (int c = 0; c < 3000 && ok == 0; c++) begin
                @(negedge clk);
                ok = int'(RecReady);
                tick();
            end
            check($sformatf("s%0d_accept_rec%0d", id, r), 64'(ok), 64'd1);
            if (ok == 0) break;
        end
        RecValid = 1'b0;
        for (int c = 0; c < 5000 && got_q.size() < exp_q.size(); c++) tick();
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (RecReady) break;
        end
        tick();
        Flush = 1'b0; rand_rdy = 1'b0;

        // Comparisons.
        check($sformatf("s%0d_word_count", id), 64'(got_q.size()), 64'(exp_q.size()));
        n_bad = 0; first_bad = -1; nlast = 0; first_tr = '0;
        for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i][32]) begin
                if (nlast == 0) first_tr = got_q[i][31:0];
                nlast++;
            end
            if (i < exp_q.size() && got_q[i] !== exp_q[i]) begin
                if (first_bad < 0) first_bad = i;
                n_bad++;
            end
        end
        check($sformatf("s%0d_stream_bad_words(first_idx=%0d)", id, first_bad), 64'(n_bad), 64'd0);
        check($sformatf("s%0d_wlast_count", id), 64'(nlast), 64'(v.exp_frames));
        check($sformatf("s%0d_first_trailer", id), {32'd0, first_tr},
              {32'd0, 16'(v.exp_cnt1), 16'h5256});
        check($sformatf("s%0d_frame_count", id), FrameCount, fc0 + 64'(v.exp_frames));
        if (!v.rnd && got_q.size() == exp_q.size()) begin
            for (int f = 0; f < tr_idx.size(); f++) begin
                t = tr_idx[f];
                d = got_cyc[t] - got_cyc[t-1];
                expd = (v.flush || f < tr_idx.size() - 1) ? 2 : v.idle + 2;
                check($sformatf("s%0d_f%0d_open_cycles", id, f), 64'(d), 64'(expd));
                if (f < tr_idx.size() - 1) begin
                    d = got_cyc[t+1] - got_cyc[t];
                    check($sformatf("s%0d_f%0d_gap_cycles", id, f), 64'(d), 64'(v.gap + 3));
                end
            end
        end
        fc_out = fc0 + 64'(v.exp_frames);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] fc, fc_n;
        int ok;
        //          nrec len idle gap rnd flush frames cnt1
        tbl[0] = '{1,   3,  10,  0,  0,  0,    1,     1};
        tbl[1] = '{1,   0,  2,   0,  0,  0,    1,     1};
        tbl[2] = '{2,   50, 2,   1,  0,  0,    1,     2};
        tbl[3] = '{4,   100,2,   3,  0,  0,    2,     3};
        tbl[4] = '{4,   92, 2,   0,  0,  0,    1,     4};
        tbl[5] = '{4,   93, 2,   0,  0,  0,    2,     3};
        tbl[6] = '{3,   7,  3,   2,  1,  0,    1,     3};
        tbl[7] = '{5,   32, 1,   0,  1,  0,    1,     5};
        tbl[8] = '{2,   2,  4,   1,  0,  1,    2,     1};

        reset = 1'b1; RecValid = 1'b0; Flush = 1'b0; RecData = '0; RecWords = '0;
        IdleTimeout = 32'd10; InterPktGap = 32'd0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_wvalid", {63'd0, Wvalid}, 64'd0);
        check("rst_wlast", {63'd0, Wlast}, 64'd0);
        check("rst_recready", {63'd0, RecReady}, 64'd0);
        check("rst_frame_count", FrameCount, 64'd0);
        check("rst_wstrb", {60'd0, Wstrb}, 64'hF);
        tick();
        reset = 1'b0;
        init_check("init");

        fc = 64'd0;
        for (int i = 0; i < 9; i++) begin
            run_scn(i, tbl[i], fc, fc_n);
            fc = fc_n;
        end

        // Reset in the middle of a record body.
        @(negedge clk);
        check("pre_reset_frame_count", FrameCount, 64'd12);
        tick();
        got_q.delete(); got_cyc.delete();
        IdleTimeout = 32'd2; InterPktGap = 32'd0;
        RecData = '0;
        for (int k = 0; k < 20; k++) RecData[k*32 +: 32] = rec_w(200, k);
        RecWords = RW_W'(20);
        RecValid = 1'b1;
        ok = 0;
        for (int c = 0; c < 100 && ok == 0; c++) begin
            @(negedge clk);
            ok = int'(RecReady);
            tick();
        end
        check("midbody_accept", 64'(ok), 64'd1);
        RecValid = 1'b0;
        for (int c = 0; c < 100 && got_q.size() < 10; c++) tick();
        check("midbody_words_before_reset", 64'(got_q.size()), 64'd10);
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("midbody_reset_wvalid", {63'd0, Wvalid}, 64'd0);
        check("midbody_reset_frame_count", FrameCount, 64'd0);
        tick();
        reset = 1'b0;
        init_check("reinit");
        run_scn(9, tbl[0], 64'd0, fc_n);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
